// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
// Imported by the controller top.
package serial_adder_ctrl_pkg;

  // Default operand/result width in bits (legal range >= 2).
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The unused code 2'd3 falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Latency: 0 cycles. Backpressure: none (no state, no handshake).
// Ports: a, b, c = addend bits and carry-in; sum, carry = result bit and carry-out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c;
  assign carry = (a & b) | (c & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder, one bit per clock, LSB first.
// Latency: res_valid rises exactly WIDTH edges after the accept edge.
// Backpressure: result held in DONE until res_ready; start_ready is high only in IDLE.
// Ports:
//   clk, rst                  clock, async active-high reset
//   start_valid/start_ready   operand handshake; op_a, op_b, cin sampled at the accept edge
//   res_valid/res_ready       result handshake; sum, cout registered result
//   busy                      controller is not idle
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t         state;
  state_t         state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;

  logic accept;
  logic last_bit;
  logic fa_sum;
  logic fa_carry;

  assign accept   = start_valid && start_ready;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)    state_nxt = ST_DONE;
      ST_DONE: if (res_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry flop, bit counter and result registers.
  // sum/cout load only on the final bit so they stay stable through IDLE/RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= op_b;
      carry_q <= cin;
      bit_cnt <= '0;
    end else if (state == ST_RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
      carry_q <= fa_carry;
      if (last_bit) begin
        // Counter parks at WIDTH-1 instead of wrapping; reloaded on next accept.
        sum  <= {fa_sum, sum_sr[WIDTH-1:1]};
        cout <= fa_carry;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule
